// File: rtl/bconv_col_engine.sv
// Streaming binary 3x3 convolution: slides a 3-column window over incoming columns,
// XNOR-matches it against a latched kernel and emits one sign bit per output column.
module bconv_col_engine #(
    parameter int IDX_W  = 4,
    parameter int THRESH = 5
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [15:0]      weights_data,
    input  logic             weights_load,
    input  logic             row_start,
    input  logic             d_valid,
    input  logic [2:0]       d_in,
    output logic             res_valid,
    output logic             res_bit,
    output logic [IDX_W-1:0] res_idx,
    output logic             busy
);

    logic [8:0]       kernel_q;
    logic [2:0]       win0_q, win1_q, win2_q;
    logic [2:0]       win0_d, win1_d, win2_d;
    logic [1:0]       fill_q, fill_d;
    logic [IDX_W-1:0] col_cnt_q, col_cnt_d;
    logic             eval_q, eval_d;

    logic [2:0][1:0]  s1_cnt_q, s1_cnt_d;
    logic [IDX_W-1:0] s1_idx_q;
    logic             s1_valid_q;

    logic             res_valid_q, res_bit_q;
    logic [IDX_W-1:0] res_idx_q;
    logic [3:0]       match_sum;

    logic unused_weights;
    assign unused_weights = ^weights_data[15:9];

    // Matches in one kernel row; bit c of both operands is window column c (0 oldest).
    function automatic logic [1:0] row_match(input logic [2:0] bits, input logic [2:0] w);
        logic [2:0] x;
        x = ~(bits ^ w);
        return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
    endfunction

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        win0_d    = win0_q;
        win1_d    = win1_q;
        win2_d    = win2_q;
        fill_d    = fill_q;
        col_cnt_d = col_cnt_q;
        eval_d    = 1'b0;
        if (row_start) begin
            win0_d = '0;
            win1_d = '0;
            if (d_valid) begin
                win2_d    = d_in;
                fill_d    = 2'd1;
                col_cnt_d = IDX_W'(1);
            end else begin
                win2_d    = '0;
                fill_d    = 2'd0;
                col_cnt_d = '0;
            end
        end else if (d_valid) begin
            win0_d    = win1_q;
            win1_d    = win2_q;
            win2_d    = d_in;
            col_cnt_d = col_cnt_q + 1'b1;
            fill_d    = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
            eval_d    = (fill_q >= 2'd2);
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            s1_cnt_d[r] = row_match({win2_q[r], win1_q[r], win0_q[r]}, kernel_q[3*r +: 3]);
        end
    end

    assign match_sum = {2'b00, s1_cnt_q[0]} + {2'b00, s1_cnt_q[1]} + {2'b00, s1_cnt_q[2]};

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            kernel_q    <= '0;
            win0_q      <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            fill_q      <= '0;
            col_cnt_q   <= '0;
            eval_q      <= 1'b0;
            s1_cnt_q    <= '0;
            s1_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_bit_q   <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            if (weights_load) begin
                kernel_q <= weights_data[8:0];
            end
            win0_q    <= win0_d;
            win1_q    <= win1_d;
            win2_q    <= win2_d;
            fill_q    <= fill_d;
            col_cnt_q <= col_cnt_d;
            eval_q    <= eval_d;

            s1_valid_q <= eval_q;
            if (eval_q) begin
                s1_cnt_q <= s1_cnt_d;
                s1_idx_q <= col_cnt_q - IDX_W'(3);
            end

            // Result fields hold their last values between pulses.
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_bit_q <= (match_sum >= 4'(THRESH));
                res_idx_q <= s1_idx_q;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_bit   = res_bit_q;
    assign res_idx   = res_idx_q;
    assign busy      = eval_q | s1_valid_q | res_valid_q;

endmodule
